// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single FPGA-to-AVR serial transmitter between two requesters:
// 48-bit TDC measurement records and 8-bit status/acknowledge bytes. Each
// granted request is framed as header, payload and XOR checksum, and the
// bytes are paced against the transmitter's tx_busy/tx_block flags.
//
// Handshake (both request ports): the requester holds *_valid with stable
// *_data until it sees the one-cycle *_ready pulse. The data is captured on
// the same clock edge that raises *_ready. Dropping *_valid before *_ready
// withdraws the request. Grants are only issued from IDLE, so a request is
// never accepted while another packet is being sent.
//
// Measurement traffic has priority. A burst counter, cleared by every status
// grant, lets a pending status byte through after MAX_MEAS_BURST back-to-back
// measurement packets.
module uart_tx_arbiter #(
  parameter logic [7:0]  MEAS_HDR       = 8'hA5,
  parameter logic [7:0]  STAT_HDR       = 8'h5A,
  parameter int unsigned MAX_MEAS_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_reset,
  input  logic        meas_valid,
  input  logic [47:0] meas_data,
  output logic        meas_ready,
  input  logic        stat_valid,
  input  logic [7:0]  stat_data,
  output logic        stat_ready,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  input  logic        tx_block,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_MEAS_BURST);
  localparam logic [3:0] MEAS_LEN  = 4'd8;
  localparam logic [3:0] STAT_LEN  = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;

  logic            grant_meas;
  logic            grant_stat;
  logic            tx_free;
  logic            bytes_left;
  logic [7:0]      meas_xor;

  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic [3:0]      pkt_len_q, pkt_len_d;
  logic            is_stat_q, is_stat_d;
  logic [7:0][7:0] pkt_buf_q, pkt_buf_d;

  logic [7:0]      tx_data_q, tx_data_d;
  logic            new_tx_data_q, new_tx_data_d;
  logic            meas_ready_q, meas_ready_d;
  logic            stat_ready_q, stat_ready_d;
  logic            busy_q, busy_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;

  // Transmitter can take a byte this cycle.
  assign tx_free = !tx_busy && !tx_block;

  // byte_idx already points past the byte just sent while in GAP.
  assign bytes_left = (byte_idx_q < pkt_len_q);

  // Checksum of the six payload bytes of a measurement record.
  assign meas_xor = meas_data[47:40] ^ meas_data[39:32] ^ meas_data[31:24] ^
                    meas_data[23:16] ^ meas_data[15:8]  ^ meas_data[7:0];

  // State and datapath registers; rst returns everything to reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      burst_cnt_q   <= 4'd0;
      byte_idx_q    <= 4'd0;
      pkt_len_q     <= 4'd0;
      is_stat_q     <= 1'b0;
      pkt_buf_q     <= '0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
      meas_ready_q  <= 1'b0;
      stat_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      pkt_cnt_q     <= 16'h0000;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      byte_idx_q    <= byte_idx_d;
      pkt_len_q     <= pkt_len_d;
      is_stat_q     <= is_stat_d;
      pkt_buf_q     <= pkt_buf_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      meas_ready_q  <= meas_ready_d;
      stat_ready_q  <= stat_ready_d;
      busy_q        <= busy_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  // Next-state logic including the IDLE arbitration decision.
  always_comb begin
    state_d    = state_q;
    grant_meas = 1'b0;
    grant_stat = 1'b0;
    if (soft_reset) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stat_valid && (!meas_valid || (burst_cnt_q == BURST_MAX))) begin
            grant_stat = 1'b1;
            state_d    = S_LOAD;
          end else if (meas_valid) begin
            grant_meas = 1'b1;
            state_d    = S_LOAD;
          end
        end
        S_LOAD: state_d = S_SEND;
        S_SEND: begin
          if (tx_free) begin
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          // One-cycle hold-off covers the transmitter's busy latency.
          if (bytes_left) begin
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs, packet buffer, byte pacing and counters.
  always_comb begin
    burst_cnt_d   = burst_cnt_q;
    byte_idx_d    = byte_idx_q;
    pkt_len_d     = pkt_len_q;
    is_stat_d     = is_stat_q;
    pkt_buf_d     = pkt_buf_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    meas_ready_d  = 1'b0;
    stat_ready_d  = 1'b0;
    pkt_cnt_d     = pkt_cnt_q;
    busy_d        = (state_d != S_IDLE);

    if (soft_reset) begin
      // Abandon any partial packet; only the packet counter survives.
      burst_cnt_d = 4'd0;
      byte_idx_d  = 4'd0;
      pkt_len_d   = 4'd0;
      is_stat_d   = 1'b0;
      pkt_buf_d   = '0;
      tx_data_d   = 8'h00;
    end else begin
      if (grant_meas) begin
        meas_ready_d = 1'b1;
        is_stat_d    = 1'b0;
        pkt_buf_d[0] = MEAS_HDR;
        pkt_buf_d[1] = meas_data[47:40];
        pkt_buf_d[2] = meas_data[39:32];
        pkt_buf_d[3] = meas_data[31:24];
        pkt_buf_d[4] = meas_data[23:16];
        pkt_buf_d[5] = meas_data[15:8];
        pkt_buf_d[6] = meas_data[7:0];
        pkt_buf_d[7] = meas_xor;
        if (burst_cnt_q != BURST_MAX) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end

      if (grant_stat) begin
        stat_ready_d = 1'b1;
        is_stat_d    = 1'b1;
        pkt_buf_d    = '0;
        pkt_buf_d[0] = STAT_HDR;
        pkt_buf_d[1] = stat_data;
        // XOR over a single payload byte is the byte itself.
        pkt_buf_d[2] = stat_data;
        burst_cnt_d  = 4'd0;
      end

      case (state_q)
        S_LOAD: begin
          byte_idx_d = 4'd0;
          pkt_len_d  = is_stat_q ? STAT_LEN : MEAS_LEN;
        end
        S_SEND: begin
          if (tx_free) begin
            tx_data_d     = pkt_buf_q[byte_idx_q[2:0]];
            new_tx_data_d = 1'b1;
            byte_idx_d    = byte_idx_q + 4'd1;
          end
        end
        S_GAP: begin
          if (!bytes_left) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign meas_ready  = meas_ready_q;
  assign stat_ready  = stat_ready_q;
  assign busy        = busy_q;
  assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. Expected packets are built from the
// framing rules into a byte queue (exp_q) and an ordered grant queue; a single
// negedge compare process walks both with read pointers, checks every strobe,
// every ready pulse and pkt_cnt on every cycle, and the directed sequence adds
// literal expectations for the documented scenarios.
module tb_uart_tx_arbiter;

  localparam logic [7:0] MEAS_HDR = 8'hA5;
  localparam logic [7:0] STAT_HDR = 8'h5A;
  localparam int         TMO      = 3000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        soft_reset  = 1'b0;
  logic        meas_valid  = 1'b0;
  logic [47:0] meas_data   = '0;
  logic        meas_ready;
  logic        stat_valid  = 1'b0;
  logic [7:0]  stat_data   = '0;
  logic        stat_ready;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy     = 1'b0;
  logic        tx_block    = 1'b0;
  logic        busy;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .MEAS_HDR      (MEAS_HDR),
    .STAT_HDR      (STAT_HDR),
    .MAX_MEAS_BURST(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .meas_valid (meas_valid),
    .meas_data  (meas_data),
    .meas_ready (meas_ready),
    .stat_valid (stat_valid),
    .stat_data  (stat_data),
    .stat_ready (stat_ready),
    .tx_data    (tx_data),
    .new_tx_data(new_tx_data),
    .tx_busy    (tx_busy),
    .tx_block   (tx_block),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [8:0]  exp_q[$];        // {last_byte_of_packet, byte}
  logic        exp_grant_q[$];  // 0 = measurement, 1 = status
  logic [7:0]  obs_q[$];
  int          flush_gen = 0;

  int          cyc = 0;
  int          rd_ptr = 0;
  int          gr_ptr = 0;
  int          seen_gen = 0;
  int          last_strobe_cyc = -100;
  int          last_ready_cyc = -100;
  logic        mid_pkt = 1'b0;
  logic        inc_pending = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] model_cnt = 16'h0000;
  logic        blk_s = 1'b0;

  logic [47:0] starve_d [6] = '{48'h111111111111, 48'h222222222222, 48'h3456789ABCDE,
                                48'h444444444444, 48'h555555555555, 48'h66778899AABB};

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] meas_xor(input logic [47:0] d);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 6; i++) x = x ^ d[i*8 +: 8];
    return x;
  endfunction

  function automatic void push_meas(input logic [47:0] d);
    exp_q.push_back({1'b0, MEAS_HDR});
    for (int i = 5; i >= 0; i--) exp_q.push_back({1'b0, d[i*8 +: 8]});
    exp_q.push_back({1'b1, meas_xor(d)});
    exp_grant_q.push_back(1'b0);
  endfunction

  function automatic void push_stat(input logic [7:0] s);
    exp_q.push_back({1'b0, STAT_HDR});
    exp_q.push_back({1'b0, s});
    exp_q.push_back({1'b1, s});
    exp_grant_q.push_back(1'b1);
  endfunction

  // Transmitter-side condition seen by the DUT on each active edge.
  always @(posedge clk) blk_s <= tx_block || tx_busy;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (flush_gen != seen_gen) begin
      seen_gen    = flush_gen;
      rd_ptr      = exp_q.size();
      gr_ptr      = exp_grant_q.size();
      mid_pkt     = 1'b0;
      inc_pending = 1'b0;
    end
    if (rst) begin
      model_cnt   = 16'h0000;
      inc_pending = 1'b0;
      mid_pkt     = 1'b0;
      prev_ready  = 1'b0;
    end else begin
      if (inc_pending) begin
        model_cnt   = model_cnt + 16'd1;
        inc_pending = 1'b0;
      end
      check("pkt_cnt_model", pkt_cnt, model_cnt);

      if (meas_ready || stat_ready) begin
        check("ready_both_high", meas_ready && stat_ready, 1'b0);
        check("ready_pulse_width", prev_ready, 1'b0);
        check("grant_mid_packet", mid_pkt, 1'b0);
        if (gr_ptr >= exp_grant_q.size()) begin
          check("unexpected_grant", {meas_ready, stat_ready}, 2'b00);
        end else begin
          check("grant_order", stat_ready, exp_grant_q[gr_ptr]);
          gr_ptr++;
        end
        last_ready_cyc = cyc;
      end
      prev_ready = meas_ready || stat_ready;

      if (new_tx_data) begin
        obs_q.push_back(tx_data);
        check("strobe_while_blocked", blk_s, 1'b0);
        check("strobe_spacing_ok", (cyc - last_strobe_cyc) >= 2, 1'b1);
        if (rd_ptr >= exp_q.size()) begin
          check("unexpected_strobe", {1'b1, tx_data}, 9'h000);
        end else begin
          check("tx_byte", tx_data, exp_q[rd_ptr][7:0]);
          if (!mid_pkt) check("first_strobe_latency_ok", (cyc - last_ready_cyc) >= 2, 1'b1);
          mid_pkt     = !exp_q[rd_ptr][8];
          inc_pending = exp_q[rd_ptr][8];
          rd_ptr++;
        end
        last_strobe_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_meas(input logic [47:0] d);
    int n;
    n = 0;
    meas_data  = d;
    meas_valid = 1'b1;
    tick();
    while (!meas_ready && n < TMO) begin
      tick();
      n++;
    end
    if (!meas_ready) check("meas_ready_timeout", 1'b0, 1'b1);
    meas_valid = 1'b0;
  endtask

  task automatic drive_stat(input logic [7:0] s);
    int n;
    n = 0;
    stat_data  = s;
    stat_valid = 1'b1;
    tick();
    while (!stat_ready && n < TMO) begin
      tick();
      n++;
    end
    if (!stat_ready) check("stat_ready_timeout", 1'b0, 1'b1);
    stat_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int cnt);
    int seen;
    int n;
    seen = 0;
    n = 0;
    while (seen < cnt && n < TMO) begin
      tick();
      n++;
      if (new_tx_data) seen++;
    end
    if (seen < cnt) check("strobe_timeout", seen, cnt);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((rd_ptr != exp_q.size() || gr_ptr != exp_grant_q.size() || busy) && n < TMO) begin
      tick();
      n++;
    end
    check({name, "_all_sent"}, n < TMO, 1'b1);
    check({name, "_busy_low"}, busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] lit1 [8] = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'h22};
  logic [7:0] lit2 [3] = '{8'h5A, 8'h3C, 8'h3C};

  initial begin
    int cnt;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_new_tx_data", new_tx_data, 1'b0);
    check("rst_meas_ready", meas_ready, 1'b0);
    check("rst_stat_ready", stat_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_cnt", pkt_cnt, 16'h0000);
    rst = 1'b0;
    tick();

    // Model pin: checksum of the reference record
    check("model_xor_pin", meas_xor(48'h0123456789AB), 8'h22);

    // Single measurement packet
    push_meas(48'h0123456789AB);
    drive_meas(48'h0123456789AB);
    wait_done("single_meas");
    check("single_meas_bytes", obs_q.size(), 8);
    if (obs_q.size() >= 8)
      for (int i = 0; i < 8; i++) check("single_meas_literal", obs_q[i], lit1[i]);
    check("single_meas_pkt_cnt", pkt_cnt, 16'd1);

    // Single status packet
    push_stat(8'h3C);
    drive_stat(8'h3C);
    wait_done("single_stat");
    check("single_stat_bytes", obs_q.size(), 11);
    if (obs_q.size() >= 11)
      for (int i = 0; i < 3; i++) check("single_stat_literal", obs_q[8+i], lit2[i]);
    check("single_stat_pkt_cnt", pkt_cnt, 16'd2);

    // Starvation guard: 4 measurement packets, then status, then measurements
    for (int k = 0; k < 4; k++) push_meas(starve_d[k]);
    push_stat(8'hC3);
    push_meas(starve_d[4]);
    push_meas(starve_d[5]);
    fork
      begin
        for (int k = 0; k < 6; k++) drive_meas(starve_d[k]);
      end
      begin
        repeat (4) tick();
        drive_stat(8'hC3);
      end
    join
    wait_done("starve");
    check("starve_pkt_cnt", pkt_cnt, 16'd9);

    // Simultaneous requests from idle: measurement first (burst not saturated)
    push_meas(48'hFEDCBA987654);
    push_stat(8'h81);
    fork
      drive_meas(48'hFEDCBA987654);
      drive_stat(8'h81);
    join
    wait_done("simul");
    check("simul_pkt_cnt", pkt_cnt, 16'd11);

    // tx_block stall after 3rd strobe, plus a withdrawn status request
    push_meas(48'h0123456789AB);
    drive_meas(48'h0123456789AB);
    wait_strobes(3);
    tx_block   = 1'b1;
    stat_data  = 8'h99;
    stat_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (new_tx_data) cnt++;
      if (i == 50) stat_valid = 1'b0;
    end
    check("block_no_strobes", cnt, 0);
    tx_block = 1'b0;
    wait_strobes(1);
    check("block_resume_byte", tx_data, 8'h45);
    wait_done("block");
    check("block_pkt_cnt", pkt_cnt, 16'd12);

    // Same with tx_busy held
    push_meas(48'h0123456789AB);
    drive_meas(48'h0123456789AB);
    wait_strobes(3);
    tx_busy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (new_tx_data) cnt++;
    end
    check("txbusy_no_strobes", cnt, 0);
    tx_busy = 1'b0;
    wait_strobes(1);
    check("txbusy_resume_byte", tx_data, 8'h45);
    wait_done("txbusy");
    check("txbusy_pkt_cnt", pkt_cnt, 16'd13);

    // rst after the 2nd strobe
    push_meas(48'h0123456789AB);
    drive_meas(48'h0123456789AB);
    wait_strobes(2);
    rst = 1'b1;
    #1;
    check("rst_mid_new_tx_data", new_tx_data, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_pkt_cnt", pkt_cnt, 16'd0);
    tick();
    rst = 1'b0;
    flush_gen++;
    tick();
    push_meas(48'h102030405060);
    drive_meas(48'h102030405060);
    wait_strobes(1);
    check("after_rst_first_byte", tx_data, MEAS_HDR);
    wait_done("after_rst");
    check("after_rst_pkt_cnt", pkt_cnt, 16'd1);

    // soft_reset after the 2nd strobe
    push_meas(48'h0123456789AB);
    drive_meas(48'h0123456789AB);
    wait_strobes(2);
    soft_reset = 1'b1;
    tick();
    check("soft_mid_new_tx_data", new_tx_data, 1'b0);
    check("soft_mid_busy", busy, 1'b0);
    check("soft_mid_pkt_cnt", pkt_cnt, 16'd1);
    soft_reset = 1'b0;
    flush_gen++;
    tick();
    push_meas(48'h0A0B0C0D0E0F);
    drive_meas(48'h0A0B0C0D0E0F);
    wait_strobes(1);
    check("after_soft_first_byte", tx_data, MEAS_HDR);
    wait_done("after_soft");
    check("after_soft_pkt_cnt", pkt_cnt, 16'd2);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single FPGA-to-AVR serial transmitter between two requesters: 48-bit TDC measurement records and 8-bit status/acknowledge bytes from main control.
- Wraps each request in a framed packet (header, payload, XOR checksum) and paces the bytes against the transmitter's busy/block flags.
- Measurement records have priority. A burst counter stops them from starving status traffic.

Parameters:
- MEAS_HDR, 8'hA5, header byte of a measurement packet
- STAT_HDR, 8'h5A, header byte of a status packet
- MAX_MEAS_BURST, 4, consecutive measurement packets after which a pending status request wins (range 1-15)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- soft_reset  in  1  synchronous abort, same effect as rst except pkt_cnt is kept
- meas_valid  in  1  measurement record pending; held until accepted
- meas_data  in  48  measurement record
- meas_ready  out  1  one-cycle accept pulse; meas_data is latched in this cycle
- stat_valid  in  1  status byte pending; held until accepted
- stat_data  in  8  status byte
- stat_ready  out  1  one-cycle accept pulse
- tx_data  out  8  byte to the serial transmitter
- new_tx_data  out  1  one-cycle strobe, tx_data valid
- tx_busy  in  1  transmitter busy
- tx_block  in  1  AVR receive buffer full
- busy  out  1  packet in progress (state != IDLE)
- pkt_cnt  out  16  completed packets, wraps 16'hFFFF->0

Behaviour:
- All outputs are registered.
- Reset values: tx_data=0, new_tx_data=0, meas_ready=0, stat_ready=0, busy=0, pkt_cnt=0. Internal: state=IDLE, burst_cnt=0.
- States:
  - IDLE: arbitration.
  - LOAD: builds the packet.
  - SEND: waits for the transmitter to be free.
  - GAP: one-cycle hold-off after each strobe.
- IDLE grant rule, evaluated every cycle:
  - if stat_valid && (!meas_valid || burst_cnt==MAX_MEAS_BURST): grant status;
  - else if meas_valid: grant measurement;
  - else stay in IDLE.
- On a grant:
  - the matching ready pulses high for exactly one cycle, in the cycle after valid is sampled;
  - data is copied into the internal packet buffer;
  - state goes to LOAD.
- burst_cnt:
  - +1 on each measurement grant, saturating at MAX_MEAS_BURST;
  - cleared on each status grant.
- Packet formats:
  - measurement: 8 bytes = MEAS_HDR, meas_data[47:40], [39:32], [31:24], [23:16], [15:8], [7:0], then the XOR of the 6 payload bytes;
  - status: 3 bytes = STAT_HDR, stat_data, stat_data (the XOR of a single byte).
- LOAD: sets byte index to 0 and packet length to 8 or 3, then goes to SEND.
- SEND: when !tx_busy && !tx_block:
  - drive tx_data with the current byte;
  - pulse new_tx_data for one cycle;
  - increment the byte index;
  - go to GAP.
- GAP: lasts exactly one cycle and ignores tx_busy, covering the transmitter's one-cycle busy latency.
  - if bytes remain: go to SEND;
  - else: increment pkt_cnt and go to IDLE.
- Minimum turnaround:
  - first strobe no earlier than 2 cycles after the ready pulse;
  - strobes are at least 2 cycles apart.
- tx_block asserted mid-packet: the packet stalls in SEND with no strobes and resumes at the same byte index. Bytes are never dropped or repeated.
- A request with valid held during another packet waits. It is never accepted mid-packet.
- valid deasserted before it is granted: the request is withdrawn, with no ready pulse.
- rst mid-packet: immediate return to reset values; the partial packet is abandoned.
- soft_reset mid-packet: same as rst on the next clock edge, except pkt_cnt is held.
- rst has priority over soft_reset.

Test Plan:
- Single measurement, meas_data=48'h0123456789AB, tx_busy=0 -> meas_ready pulses once; strobes carry A5 01 23 45 67 89 AB 22; pkt_cnt=1; busy drops after the last GAP.
- Single status, stat_data=8'h3C -> stat_ready pulses once; strobes carry 5A 3C 3C; pkt_cnt increments by 1.
- Starvation guard: meas_valid held high continuously, stat_valid raised during the 1st measurement packet -> exactly 4 measurement packets, then the status packet, then measurements resume; burst_cnt is cleared by the status grant.
- Simultaneous meas_valid and stat_valid from idle with burst_cnt=0 -> measurement granted first; stat_ready stays 0 until that packet completes.
- tx_block raised after the 3rd strobe of a measurement packet, held for 100 cycles -> no strobes for those cycles; after release the 4th byte (8'h45 for the first test's data) follows with no loss or duplication. Repeat with tx_busy held, same result.
- rst pulsed, then separately soft_reset pulsed, each after the 2nd strobe of a measurement packet -> new_tx_data=0 and busy=0 immediately; rst clears pkt_cnt to 0, soft_reset keeps it; the next packet starts with MEAS_HDR.
